// File: rtl/cnn_maxpool_2x2_if.sv
// Pixel stream bundle for the 2x2 max-pooling stage: raw conv pixels in,
// pooled pixels with their map coordinates out.
interface cnn_maxpool_2x2_if #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 24,
  parameter int IMG_H  = 24
);
  localparam int COL_W = ((IMG_W / 2) > 1) ? $clog2(IMG_W / 2) : 1;
  localparam int ROW_W = ((IMG_H / 2) > 1) ? $clog2(IMG_H / 2) : 1;

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [COL_W-1:0]  out_col;
  logic [ROW_W-1:0]  out_row;
  logic              frame_done;

  modport master (
    output in_valid, in_data,
    input  out_valid, out_data, out_col, out_row, frame_done
  );

  modport slave (
    input  in_valid, in_data,
    output out_valid, out_data, out_col, out_row, frame_done
  );
endinterface

// File: rtl/cnn_maxpool_2x2.sv
// Streaming 2x2 / stride-2 max pooling over a raster-ordered feature map.
// Keeps one row of horizontal pair maxima; no frame memory.
module cnn_maxpool_2x2 #(
  parameter int IMG_W  = 24,
  parameter int IMG_H  = 24,
  parameter int DATA_W = 8,
  parameter int SIGNED = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  cnn_maxpool_2x2_if.slave  pif
);
  localparam int OUT_W    = IMG_W / 2;
  localparam int OUT_H    = IMG_H / 2;
  localparam int COL_W    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int ROW_W    = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int IN_COL_W = $clog2(IMG_W);
  localparam int IN_ROW_W = $clog2(IMG_H);

  localparam logic [IN_COL_W-1:0] COL_LAST = IN_COL_W'(IMG_W - 1);
  localparam logic [IN_ROW_W-1:0] ROW_LAST = IN_ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0]    K_LAST   = COL_W'(OUT_W - 1);
  localparam logic [ROW_W-1:0]    RK_LAST  = ROW_W'(OUT_H - 1);
  localparam bit                  W_ODD    = (IMG_W % 2) != 0;
  localparam bit                  H_ODD    = (IMG_H % 2) != 0;

  function automatic logic [DATA_W-1:0] pix_max(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    logic a_ge;
    if (SIGNED != 0) begin
      a_ge = $signed(a) >= $signed(b);
    end else begin
      a_ge = a >= b;
    end
    if (a_ge) begin
      return a;
    end else begin
      return b;
    end
  endfunction

  logic [IN_COL_W-1:0] in_col_r, in_col_s;
  logic [IN_ROW_W-1:0] in_row_r, in_row_s;
  logic [DATA_W-1:0]   h_r, h_s;
  logic [DATA_W-1:0]   linebuf_r [OUT_W];

  logic                out_valid_r, out_valid_s;
  logic [DATA_W-1:0]   out_data_r, out_data_s;
  logic [COL_W-1:0]    out_col_r, out_col_s;
  logic [ROW_W-1:0]    out_row_r, out_row_s;
  logic                frame_done_r, frame_done_s;

  logic [DATA_W-1:0]   hmax_s;
  logic [COL_W-1:0]    k_s;
  logic [ROW_W-1:0]    rk_s;
  logic                lb_we_s;
  logic                col_used_s;
  logic                row_used_s;

  assign hmax_s = pix_max(h_r, pif.in_data);
  assign k_s    = COL_W'(in_col_r >> 1);
  assign rk_s   = ROW_W'(in_row_r >> 1);

  // A trailing odd column/row is counted but never enters a window.
  assign col_used_s = !(W_ODD && (in_col_r == COL_LAST));
  assign row_used_s = !(H_ODD && (in_row_r == ROW_LAST));

  // Next-state: raster counters, horizontal pair, vertical merge and output.
  always_comb begin
    in_col_s     = in_col_r;
    in_row_s     = in_row_r;
    h_s          = h_r;
    lb_we_s      = 1'b0;
    out_valid_s  = 1'b0;
    out_data_s   = out_data_r;
    out_col_s    = out_col_r;
    out_row_s    = out_row_r;
    frame_done_s = 1'b0;

    if (pif.in_valid) begin
      if (in_col_r == COL_LAST) begin
        in_col_s = '0;
        if (in_row_r == ROW_LAST) begin
          in_row_s = '0;
        end else begin
          in_row_s = in_row_r + IN_ROW_W'(1);
        end
      end else begin
        in_col_s = in_col_r + IN_COL_W'(1);
      end

      if (!in_col_r[0]) begin
        if (col_used_s) begin
          h_s = pif.in_data;
        end else begin
          h_s = h_r;
        end
      end else if (row_used_s) begin
        if (!in_row_r[0]) begin
          lb_we_s = 1'b1;
        end else begin
          out_valid_s  = 1'b1;
          out_data_s   = pix_max(linebuf_r[k_s], hmax_s);
          out_col_s    = k_s;
          out_row_s    = rk_s;
          frame_done_s = (k_s == K_LAST) && (rk_s == RK_LAST);
        end
      end else begin
        lb_we_s = 1'b0;
      end
    end else begin
      out_valid_s = 1'b0;
    end
  end

  // State and output registers; rst and clr both restart the frame.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      in_col_r     <= '0;
      in_row_r     <= '0;
      h_r          <= '0;
      out_valid_r  <= 1'b0;
      out_data_r   <= '0;
      out_col_r    <= '0;
      out_row_r    <= '0;
      frame_done_r <= 1'b0;
    end else begin
      in_col_r     <= in_col_s;
      in_row_r     <= in_row_s;
      h_r          <= h_s;
      out_valid_r  <= out_valid_s;
      out_data_r   <= out_data_s;
      out_col_r    <= out_col_s;
      out_row_r    <= out_row_s;
      frame_done_r <= frame_done_s;
    end
  end

  // Line buffer of even-row pair maxima; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (lb_we_s && !(rst || clr)) begin
      linebuf_r[k_s] <= hmax_s;
    end
  end

  assign pif.out_valid  = out_valid_r;
  assign pif.out_data   = out_data_r;
  assign pif.out_col    = out_col_r;
  assign pif.out_row    = out_row_r;
  assign pif.frame_done = frame_done_r;
endmodule

// File: tb/tb_cnn_maxpool_2x2.sv
// Scoreboard bench for cnn_maxpool_2x2 over several geometries and signedness.
module tb_cnn_maxpool_2x2;
  typedef struct {
    logic [7:0] data;
    int         row;
    int         col;
    logic       done;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic clr;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;
  exp_t sb [5][$];
  logic        iv [5];
  logic [7:0]  id [5];
  logic        ov [5];
  logic [7:0]  od [5];
  logic [31:0] oc [5];
  logic [31:0] orw [5];
  logic        fd [5];
  logic        iv_q [5];
  int          done_cnt [5];
  int          out_cnt [5];
  logic [7:0]  frm [0:575];

  // 0: 4x4 unsigned, 1: 4x4 signed, 2: 24x24 signed, 3: 6x6 unsigned, 4: 5x5 unsigned
  cnn_maxpool_2x2_if #(.DATA_W(8), .IMG_W(4), .IMG_H(4)) if0 ();
  cnn_maxpool_2x2 #(.IMG_W(4), .IMG_H(4), .DATA_W(8), .SIGNED(0))
    dut0 (.clk(clk), .rst(rst), .clr(clr), .pif(if0.slave));
  cnn_maxpool_2x2_if #(.DATA_W(8), .IMG_W(4), .IMG_H(4)) if1 ();
  cnn_maxpool_2x2 #(.IMG_W(4), .IMG_H(4), .DATA_W(8), .SIGNED(1))
    dut1 (.clk(clk), .rst(rst), .clr(clr), .pif(if1.slave));
  cnn_maxpool_2x2_if #(.DATA_W(8), .IMG_W(24), .IMG_H(24)) if2 ();
  cnn_maxpool_2x2 #(.IMG_W(24), .IMG_H(24), .DATA_W(8), .SIGNED(1))
    dut2 (.clk(clk), .rst(rst), .clr(clr), .pif(if2.slave));
  cnn_maxpool_2x2_if #(.DATA_W(8), .IMG_W(6), .IMG_H(6)) if3 ();
  cnn_maxpool_2x2 #(.IMG_W(6), .IMG_H(6), .DATA_W(8), .SIGNED(0))
    dut3 (.clk(clk), .rst(rst), .clr(clr), .pif(if3.slave));
  cnn_maxpool_2x2_if #(.DATA_W(8), .IMG_W(5), .IMG_H(5)) if4 ();
  cnn_maxpool_2x2 #(.IMG_W(5), .IMG_H(5), .DATA_W(8), .SIGNED(0))
    dut4 (.clk(clk), .rst(rst), .clr(clr), .pif(if4.slave));

  assign if0.in_valid = iv[0]; assign if0.in_data = id[0];
  assign if1.in_valid = iv[1]; assign if1.in_data = id[1];
  assign if2.in_valid = iv[2]; assign if2.in_data = id[2];
  assign if3.in_valid = iv[3]; assign if3.in_data = id[3];
  assign if4.in_valid = iv[4]; assign if4.in_data = id[4];

  assign ov[0] = if0.out_valid; assign od[0] = if0.out_data; assign fd[0] = if0.frame_done;
  assign ov[1] = if1.out_valid; assign od[1] = if1.out_data; assign fd[1] = if1.frame_done;
  assign ov[2] = if2.out_valid; assign od[2] = if2.out_data; assign fd[2] = if2.frame_done;
  assign ov[3] = if3.out_valid; assign od[3] = if3.out_data; assign fd[3] = if3.frame_done;
  assign ov[4] = if4.out_valid; assign od[4] = if4.out_data; assign fd[4] = if4.frame_done;
  assign oc[0] = 32'(if0.out_col); assign orw[0] = 32'(if0.out_row);
  assign oc[1] = 32'(if1.out_col); assign orw[1] = 32'(if1.out_row);
  assign oc[2] = 32'(if2.out_col); assign orw[2] = 32'(if2.out_row);
  assign oc[3] = 32'(if3.out_col); assign orw[3] = 32'(if3.out_row);
  assign oc[4] = 32'(if4.out_col); assign orw[4] = 32'(if4.out_row);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mx(input logic [7:0] a, input logic [7:0] b, input bit sg);
    if (sg) return ($signed(a) > $signed(b)) ? a : b;
    return (a > b) ? a : b;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 5; i++) iv_q[i] <= iv[i];
  end

  task automatic mon(input int i);
    exp_t e;
    if (fd[i] && !ov[i]) check($sformatf("i%0d_done_wo_valid", i), 32'(fd[i]), 32'd0);
    if (ov[i]) begin
      out_cnt[i]++;
      if (fd[i]) done_cnt[i]++;
      check($sformatf("i%0d_valid_on_idle", i), 32'(iv_q[i]), 32'd1);
      if (sb[i].size() == 0) begin
        check($sformatf("i%0d_unexpected_out", i), 32'(sb[i].size()), 32'd1);
      end else begin
        e = sb[i].pop_front();
        check($sformatf("i%0d_data", i), 32'(od[i]), 32'(e.data));
        check($sformatf("i%0d_row", i), orw[i], e.row);
        check($sformatf("i%0d_col", i), oc[i], e.col);
        check($sformatf("i%0d_done", i), 32'(fd[i]), 32'(e.done));
        check($sformatf("i%0d_latency", i), cyc, e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 5; i++) mon(i);
  end

  // Drive npix pixels of frm into instance i; push a model result for each window end.
  task automatic send(input int i, input int w, input int h, input bit sg,
                      input int npix, input bit gaps);
    for (int p = 0; p < npix; p++) begin
      int r = p / w;
      int c = p % w;
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          iv[i] = 1'b0; id[i] = 8'($urandom);
          @(posedge clk); #1;
        end
      end
      iv[i] = 1'b1; id[i] = frm[p];
      if ((c % 2 == 1) && (r % 2 == 1) && (c < (w / 2) * 2) && (r < (h / 2) * 2)) begin
        exp_t e;
        e.data = mx(mx(frm[p-w-1], frm[p-w], sg), mx(frm[p-1], frm[p], sg), sg);
        e.row  = r / 2;
        e.col  = c / 2;
        e.done = (r / 2 == h / 2 - 1) && (c / 2 == w / 2 - 1);
        e.cyc  = cyc + 1;
        sb[i].push_back(e);
      end
      @(posedge clk); #1;
    end
    iv[i] = 1'b0;
  endtask

  task automatic drain(input int i);
    repeat (3) @(posedge clk);
    #1;
    check($sformatf("i%0d_q_empty", i), 32'(sb[i].size()), 32'd0);
  endtask

  task automatic check_zero(input int i, input string tag);
    check({tag, "_valid"}, 32'(ov[i]), 32'd0);
    check({tag, "_data"}, 32'(od[i]), 32'd0);
    check({tag, "_col"}, oc[i], 32'd0);
    check({tag, "_row"}, orw[i], 32'd0);
    check({tag, "_done"}, 32'(fd[i]), 32'd0);
  endtask

  task automatic fill_rand();
    for (int p = 0; p < 576; p++) frm[p] = 8'($urandom);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    for (int i = 0; i < 5; i++) begin
      iv[i] = 1'b0; id[i] = 8'd0; done_cnt[i] = 0; out_cnt[i] = 0;
    end
    rst = 1'b1; clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) check_zero(i, $sformatf("i%0d_reset", i));
    @(posedge clk); #1;
    rst = 1'b0;

    // 4x4 ramp, continuous then with idle gaps
    for (int p = 0; p < 16; p++) frm[p] = 8'(p);
    send(0, 4, 4, 1'b0, 16, 1'b0);
    drain(0);
    check("i0_ramp_done_cnt", done_cnt[0], 32'd1);
    send(0, 4, 4, 1'b0, 16, 1'b1);
    drain(0);

    // signed vs unsigned compare windows
    fill_rand();
    frm[0] = 8'h80; frm[1] = 8'hFF; frm[4] = 8'hFD; frm[5] = 8'hFE;
    frm[2] = 8'h7F; frm[3] = 8'h80; frm[6] = 8'h00; frm[7] = 8'h01;
    send(1, 4, 4, 1'b1, 16, 1'b0);
    drain(1);
    send(0, 4, 4, 1'b0, 16, 1'b0);
    drain(0);

    // 24x24 back-to-back random frames
    fill_rand();
    send(2, 24, 24, 1'b1, 576, 1'b0);
    fill_rand();
    send(2, 24, 24, 1'b1, 576, 1'b0);
    drain(2);
    check("i2_out_cnt", out_cnt[2], 32'd288);
    check("i2_done_cnt", done_cnt[2], 32'd2);

    // 6x6 mid-frame rst, then mid-frame clr
    fill_rand();
    send(3, 6, 6, 1'b0, 30, 1'b0);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check_zero(3, "i3_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    base = out_cnt[3];
    fill_rand();
    send(3, 6, 6, 1'b0, 36, 1'b0);
    drain(3);
    check("i3_rst_new_cnt", out_cnt[3] - base, 32'd9);

    fill_rand();
    send(3, 6, 6, 1'b0, 30, 1'b1);
    clr = 1'b1;
    @(posedge clk); @(negedge clk);
    check_zero(3, "i3_clr");
    @(posedge clk); #1;
    clr = 1'b0;
    base = out_cnt[3];
    fill_rand();
    send(3, 6, 6, 1'b0, 36, 1'b0);
    drain(3);
    check("i3_clr_new_cnt", out_cnt[3] - base, 32'd9);

    // 5x5 odd dimensions, ramp then random back-to-back
    for (int p = 0; p < 25; p++) frm[p] = 8'(p);
    send(4, 5, 5, 1'b0, 25, 1'b0);
    fill_rand();
    send(4, 5, 5, 1'b0, 25, 1'b0);
    drain(4);
    check("i4_out_cnt", out_cnt[4], 32'd8);
    check("i4_done_cnt", done_cnt[4], 32'd2);

    for (int i = 0; i < 5; i++) check($sformatf("i%0d_final_q", i), 32'(sb[i].size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/cnn_maxpool_2x2.md
Name: cnn_maxpool_2x2

Overview:
- Streaming 2x2/stride-2 max-pooling stage directly downstream of the CNN core controller.
- Consumes its raster-ordered convolution output stream (cnn_out / cnn_data_out, one 8-bit pixel per valid cycle, gaps allowed).
- Emits one pooled pixel per 2x2 window, in raster order, to the next-layer buffer.
- Buffers one row of horizontal maxima, so no frame memory is needed.

Parameters:
- IMG_W, 24, input feature-map width in pixels (>=2).
- IMG_H, 24, input feature-map height in pixels (>=2).
- DATA_W, 8, pixel width.
- SIGNED, 1, 1 = two's-complement compare, 0 = unsigned compare.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- clr  in  1  synchronous frame restart; same effect as rst on counters and outputs, line buffer contents don't-care.
- in_valid  in  1  input pixel valid (driven by cnn_out).
- in_data  in  DATA_W  input pixel (driven by cnn_data_out).
- out_valid  out  1  one-cycle pulse; pooled pixel valid.
- out_data  out  DATA_W  pooled pixel.
- out_col  out  $clog2(IMG_W/2)  column index of pooled pixel.
- out_row  out  $clog2(IMG_H/2)  row index of pooled pixel.
- frame_done  out  1  pulses together with the last pooled pixel of a frame.

Behaviour:
- Reset (rst or clr): out_valid=0, out_data=0, out_col=0, out_row=0, frame_done=0; in_col=0, in_row=0; h_reg=0.
  - rst has priority over clr.
  - A reset mid-frame discards the partial frame; the next valid pixel is frame pixel (0,0).
- Counters advance only on in_valid=1.
  - in_col wraps IMG_W-1 -> 0, incrementing in_row.
  - in_row wraps IMG_H-1 -> 0 (frame wrap).
  - in_valid=0 holds all state; out_valid=0.
- Horizontal stage, per accepted pixel:
  - Even in_col: h_reg <= in_data.
  - Odd in_col: hmax = max(h_reg, in_data), combinational.
- Vertical stage, odd in_col only, with k = in_col>>1:
  - Even in_row: linebuf[k] <= hmax. No output.
  - Odd in_row: out_data <= max(linebuf[k], hmax); out_col <= k; out_row <= in_row>>1; out_valid <= 1.
- Latency: out_valid asserts on the clock edge that accepts the bottom-right pixel of a window, i.e. registered, 1 cycle after that pixel is presented.
- max() compares signed when SIGNED=1, unsigned otherwise. On ties, either operand may be selected; the value is identical.
- No saturation or width growth: output width = DATA_W.
- Odd dimensions:
  - If IMG_W is odd, the pixel at in_col=IMG_W-1 is counted but ignored (h_reg untouched).
  - If IMG_H is odd, row IMG_H-1 is counted but produces no writes or outputs.
  - Output map size is floor(IMG_W/2) x floor(IMG_H/2).
- frame_done=1 in the same cycle as out_valid for out_row=floor(IMG_H/2)-1, out_col=floor(IMG_W/2)-1; otherwise 0.
- Back-to-back frames need no idle cycle: the pixel after the last pixel of a frame is (0,0) of the next frame.
- Line buffer: floor(IMG_W/2) entries x DATA_W, registers or 1R1W RAM. A write and a read never target the same entry in the same cycle.
- No backpressure: the consumer must accept out_valid pulses, at most one per 2 input pixels.

Test Plan:
- IMG_W=4, IMG_H=4, SIGNED=0, pixels 0..15 row-major, continuous valid -> 4 outputs 5, 7, 13, 15 at (row,col) (0,0), (0,1), (1,0), (1,1); frame_done only with the 15; each out_valid exactly 1 cycle after pixels 5, 7, 13, 15 respectively.
- Same frame with in_valid toggling 1-0-0-1 randomly -> identical output values and order; out_valid never asserted on an idle cycle.
- SIGNED=1, window {-128, -1, -3, -2} (0x80, 0xFF, 0xFD, 0xFE) -> out_data=0xFF. Same window with SIGNED=0 -> 0xFF; window {0x7F, 0x80, 0x00, 0x01} -> SIGNED=1: 0x7F, SIGNED=0: 0x80.
- Default 24x24, two back-to-back frames of random data vs. golden model -> 144 outputs per frame, exactly 2 frame_done pulses, second frame's first output at (0,0).
- rst (or clr) asserted after 30 pixels of a 4x4... use 6x6, then a full new frame -> all outputs 0 during reset; the new frame produces exactly 9 correct outputs, none derived from pre-reset data.
- IMG_W=5, IMG_H=5, pixels 0..24 -> outputs 6, 8, 16, 18 only; column-4 and row-4 pixels ignored; frame_done with the 18; the next frame starts at pixel (0,0).
